// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with a circular return-address stack.
//   clk, rst (sync, active-low)    clock and reset
//   stall, flush_valid/target      hold / redirect controls (flush wins)
//   pc_src, imm, rs1, call         next-PC select, operands, RAS push request
//   pc                             registered fetch PC
//   pc_plus4, ras_top, ras_empty   combinational views of registered state
//   misalign_err                   registered pulse for a rejected target
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_target,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            call,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            misalign_err
);

    localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JR  = 2'b10;
    localparam logic [1:0] SRC_RET = 2'b11;

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d, wr_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;

    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  cand;
    logic             misaligned;
    logic             accept;
    logic             do_push;
    logic             do_pop;

    // Views of registered state only; no input reaches these.
    assign pc_plus4  = pc + XLEN'(4);
    assign ras_empty = (cnt_q == '0);
    assign ras_top   = ras_empty ? '0 : ras_mem[top_q];

    assign jalr_sum  = rs1 + imm;

    // Candidate next PC.
    always_comb begin
        cand = pc_plus4;
        unique case (pc_src)
            SRC_SEQ: cand = pc_plus4;
            SRC_BR:  cand = pc + imm;
            SRC_JR:  cand = jalr_sum & ~XLEN'(1);
            SRC_RET: cand = ras_empty ? pc_plus4 : ras_top;
        endcase
    end

    // A rejected (misaligned) target also suppresses any RAS side effect.
    assign misaligned = cand[1];
    assign accept     = !flush_valid && !stall && !misaligned;
    assign do_push    = accept && call;
    assign do_pop     = accept && (pc_src == SRC_RET) && !ras_empty;

    // RAS pointer/count update; pop+push replaces the top entry in place.
    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = top_q;
        if (do_push && do_pop) begin
            wr_en  = 1'b1;
        end else if (do_push) begin
            wr_en  = 1'b1;
            wr_idx = top_q + PTR_W'(1);
            top_d  = top_q + PTR_W'(1);
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // PC, RAS control and error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc           <= RESET_VECTOR;
            top_q        <= '0;
            cnt_q        <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= !flush_valid && !stall && misaligned;
            if (flush_valid) begin
                pc <= flush_target;
            end else if (!stall && !misaligned) begin
                pc <= cand;
            end
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            ras_mem[wr_idx] <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed stimulus for pc_gen with a queue-based scoreboard.
module tb_pc_gen;

    localparam int unsigned     XLEN  = 32;
    localparam logic [XLEN-1:0] RVEC  = 32'h100;
    localparam int unsigned     DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            flush_valid;
    logic [XLEN-1:0] flush_target;
    logic [1:0]      pc_src;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            call;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            misalign_err;

    typedef struct {
        string           name;
        logic [XLEN-1:0] pc;
        logic            empty;
        logic [XLEN-1:0] top;
        logic            mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RVEC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush_valid(flush_valid),
        .flush_target(flush_target), .pc_src(pc_src), .imm(imm), .rs1(rs1),
        .call(call), .pc(pc), .pc_plus4(pc_plus4), .ras_top(ras_top),
        .ras_empty(ras_empty), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string fld,
                       input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", name, fld, act, want);
        end
    endtask

    // Monitor: pc_gen presents a new state every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "pc",           pc,                    e.pc);
            chk(e.name, "pc_plus4",     pc_plus4,              e.pc + 32'd4);
            chk(e.name, "ras_empty",    XLEN'(ras_empty),      XLEN'(e.empty));
            chk(e.name, "ras_top",      ras_top,               e.top);
            chk(e.name, "misalign_err", XLEN'(misalign_err),   XLEN'(e.mis));
        end
    end

    // Apply one cycle of inputs and queue the state expected after the edge.
    task automatic step(input string name, input logic r, input logic st,
                        input logic fv, input logic [XLEN-1:0] ft,
                        input logic [1:0] src, input logic [XLEN-1:0] im,
                        input logic [XLEN-1:0] r1, input logic cl,
                        input logic [XLEN-1:0] e_pc, input logic e_empty,
                        input logic [XLEN-1:0] e_top, input logic e_mis);
        exp_t e;
        rst = r; stall = st; flush_valid = fv; flush_target = ft;
        pc_src = src; imm = im; rs1 = r1; call = cl;
        @(posedge clk);
        #1;
        e.name = name; e.pc = e_pc; e.empty = e_empty; e.top = e_top; e.mis = e_mis;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush_valid = 1'b0; flush_target = '0;
        pc_src = 2'b00; imm = '0; rs1 = '0; call = 1'b0;

        // reset and free-run
        step("reset",  0,0,0,0,       2'b00,0,0,0, 32'h100,1,0,0);
        step("seq1",   1,0,0,0,       2'b00,0,0,0, 32'h104,1,0,0);
        step("seq2",   1,0,0,0,       2'b00,0,0,0, 32'h108,1,0,0);
        step("seq3",   1,0,0,0,       2'b00,0,0,0, 32'h10C,1,0,0);
        // branch backwards wrapping to 0, then jalr clearing bit 0
        step("flush10",1,0,1,32'h10,  2'b00,0,0,0, 32'h10,1,0,0);
        step("branch", 1,0,0,0,       2'b01,32'hFFFFFFF0,0,0, 32'h0,1,0,0);
        step("jalr",   1,0,0,0,       2'b10,32'h4,32'h2001,0, 32'h2004,1,0,0);
        // misaligned jalr with call: hold, pulse, no push; repeated cycle re-asserts
        step("mis1",   1,0,0,0,       2'b10,32'h2,32'h1000,1, 32'h2004,1,0,1);
        step("mis2",   1,0,0,0,       2'b10,32'h2,32'h1000,1, 32'h2004,1,0,1);
        step("misclr", 1,0,0,0,       2'b00,0,0,0, 32'h2008,1,0,0);
        // five calls from 0x0..0x40, fifth overwrites the oldest
        step("flush0", 1,0,1,32'h0,   2'b00,0,0,0, 32'h0,1,0,0);
        step("call1",  1,0,0,0,       2'b01,32'h10,0,1, 32'h10,0,32'h4,0);
        step("call2",  1,0,0,0,       2'b01,32'h10,0,1, 32'h20,0,32'h14,0);
        step("call3",  1,0,0,0,       2'b01,32'h10,0,1, 32'h30,0,32'h24,0);
        step("call4",  1,0,0,0,       2'b01,32'h10,0,1, 32'h40,0,32'h34,0);
        step("call5",  1,0,0,0,       2'b01,32'h10,0,1, 32'h50,0,32'h44,0);
        step("ret1",   1,0,0,0,       2'b11,0,0,0, 32'h44,0,32'h34,0);
        step("ret2",   1,0,0,0,       2'b11,0,0,0, 32'h34,0,32'h24,0);
        step("ret3",   1,0,0,0,       2'b11,0,0,0, 32'h24,0,32'h14,0);
        step("ret4",   1,0,0,0,       2'b11,0,0,0, 32'h14,1,0,0);
        step("ret5",   1,0,0,0,       2'b11,0,0,0, 32'h18,1,0,0);
        // simultaneous pop and push replaces the top
        step("callA",  1,0,0,0,       2'b00,0,0,1, 32'h1C,0,32'h1C,0);
        step("retcall",1,0,0,0,       2'b11,0,0,1, 32'h1C,0,32'h20,0);
        step("retB",   1,0,0,0,       2'b11,0,0,0, 32'h20,1,0,0);
        // stall ignores call/branch; flush overrides stall, RAS untouched
        step("callC",  1,0,0,0,       2'b00,0,0,1, 32'h24,0,32'h24,0);
        step("stall1", 1,1,0,0,       2'b01,32'h100,0,1, 32'h24,0,32'h24,0);
        step("stall2", 1,1,0,0,       2'b11,0,0,1, 32'h24,0,32'h24,0);
        step("stflush",1,1,1,32'h800, 2'b11,0,0,1, 32'h800,0,32'h24,0);
        // two pushes, a misaligned pulse, then reset mid-run
        step("callD",  1,0,0,0,       2'b00,0,0,1, 32'h804,0,32'h804,0);
        step("callE",  1,0,0,0,       2'b00,0,0,1, 32'h808,0,32'h808,0);
        step("misF",   1,0,0,0,       2'b01,32'h2,0,0, 32'h808,0,32'h808,1);
        step("rstmid", 0,1,1,32'h40,  2'b01,32'h2,0,1, 32'h100,1,0,0);
        step("afterr", 1,0,0,0,       2'b00,0,0,0, 32'h104,1,0,0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined RISC-V core; successor to the single-cycle PC register. It holds the fetch PC and selects the next PC from sequential, PC-relative branch, register-indirect (JALR), return-stack prediction or an external flush target. It also supports stall and owns a circular return-address stack (RAS). It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
- XLEN, 32, PC and operand width in bits (≥ 16)
- RESET_VECTOR, 0, PC value loaded on reset (must be 4-byte aligned)
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥ 2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset on next rising edge)
- stall  in  1  hold PC and RAS this cycle
- flush_valid  in  1  load flush_target; overrides stall and pc_src
- flush_target  in  XLEN  redirect address from a later stage
- pc_src  in  2  00 sequential, 01 branch, 10 jalr, 11 return (RAS pop)
- imm  in  XLEN  sign-extended immediate for branch/jalr
- rs1  in  XLEN  base register value for jalr
- call  in  1  push pc+4 onto RAS with this update
- pc  out  XLEN  current fetch PC (registered)
- pc_plus4  out  XLEN  pc + 4 (combinational)
- ras_top  out  XLEN  top RAS entry; 0 when empty
- ras_empty  out  1  RAS holds no entries
- misalign_err  out  1  registered one-cycle pulse: rejected misaligned target

## Operation
- Priority per cycle: reset > flush_valid > stall > pc_src.
- Candidate target by pc_src: 00 pc+4; 01 pc+imm; 10 (rs1+imm) with bit 0 cleared; 11 ras_top, or pc+4 if RAS empty.
- All adds are modulo 2^XLEN; carry discarded.
- Alignment: if the candidate has bit 1 set, PC holds, misalign_err = 1 the next cycle, and the RAS is not modified (call/pop suppressed).
- Flush: pc <= flush_target unconditionally. The flush target is not alignment-checked and the RAS is untouched (no repair).
- Stall without flush: pc, RAS pointer, count and entries hold; call/pop ignored.
- RAS is a circular buffer with a top pointer and count (0..RAS_DEPTH).
- Push (call=1, accepted update): write pc+4 at top+1, advance top, count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten (wrap).
- Pop (pc_src=11, accepted update, count>0): top retreats, count−1. Pop when empty is a no-op.
- Simultaneous pop and push: the top entry is replaced by pc+4; top and count are unchanged. Covers the call-through-return case.
- Reset values: pc = RESET_VECTOR, count = 0, top = 0, misalign_err = 0, ras_empty = 1, ras_top = 0. Entry contents are don't-care.

## Timing
- One-cycle latency: inputs sampled at edge N produce the new pc visible after edge N.
- pc_plus4, ras_top and ras_empty are combinational from registered state; they are valid in the same cycle as pc.
- misalign_err asserts for exactly one cycle after the offending edge. It re-asserts each cycle the condition persists.
- Reset mid-operation: at the next edge with rst=0, all state returns to reset values regardless of stall, flush or call.
- No combinational path from any input to pc, ras_top or ras_empty.

## Test plan
- Reset then free-run: RESET_VECTOR=0x100, pc_src=00, 3 cycles → pc = 0x100, 0x104, 0x108, 0x10C; ras_empty = 1.
- Branch and jalr: at pc=0x10, imm=0xFFFFFFF0 → pc=0x0. Then rs1=0x2001, imm=0x4, pc_src=10 → pc=0x2004 (bit 0 cleared).
- Misaligned: rs1=0x1000, imm=0x2, pc_src=10 → pc holds, misalign_err=1 for one cycle, RAS count unchanged.
- Call/return with overflow (RAS_DEPTH=4): 5 calls from pc 0x0, 0x10, 0x20, 0x30, 0x40 push 0x4..0x44. Then 4 returns → pc = 0x44, 0x34, 0x24, 0x14; ras_empty=1. A 5th return → pc = pc+4.
- Stall vs flush: stall=1 with call=1 for 2 cycles → pc and RAS unchanged. Then stall=1, flush_valid=1, target 0x800 → pc = 0x800 next cycle, RAS unchanged.
- Reset mid-run: after 2 pushes, rst=0 for one edge → pc=RESET_VECTOR, ras_empty=1, misalign_err=0.
